// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requester ports, the shared memory port and status.
// The arbiter uses the slave modport. The master modport is the requester/memory side.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 32
);
   // Port 0: CPU fetch / load-store
   logic              m0_req;
   logic              m0_we;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_ready;
   logic [DATA_W-1:0] m0_rdata;

   // Port 1: program loader / debug DMA
   logic              m1_req;
   logic              m1_we;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_ready;
   logic [DATA_W-1:0] m1_rdata;

   // Shared memory port
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Status
   logic              busy;
   logic              owner;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_ready, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_ready, m1_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output busy, owner
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_ready, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_ready, m1_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  busy, owner
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter and access sequencer for the unified instruction/data memory.
// Serialises port 0 (CPU) and port 1 (loader/DMA) onto one memory port: one-cycle strobe,
// fixed MEM_LAT wait (legal 1..15), then a one-cycle ready pulse with registered read data.
// Build option: define ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed
// priority and port 1 can starve.
module mem_arbiter #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   localparam logic [3:0] LatCnt = 4'(MEM_LAT);

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StResp
   } state_e;

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              mem_en_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] m0_rdata_q;
   logic [DATA_W-1:0] m1_rdata_q;
   logic              m0_ready_q;
   logic              m1_ready_q;
   logic              busy_q;
   logic              owner_q;

   logic              gnt_any;
   logic              gnt_port;

`ifdef ARB_RR_EN
   // Last-granted port; reset to 1 so port 0 wins the first tie.
   logic              rr_q;

   // Arbitration: on a tie grant the port opposite the last grant.
   always_comb begin
      gnt_any  = bus.m0_req | bus.m1_req;
      gnt_port = 1'b0;
      if (bus.m0_req && bus.m1_req) begin
         gnt_port = ~rr_q;
      end else begin
         gnt_port = bus.m1_req;
      end
   end

   // Pointer follows every grant taken in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q <= 1'b1;
      end else if (state_q == StIdle && gnt_any) begin
         rr_q <= gnt_port;
      end
   end
`else
   // Arbitration: port 0 wins whenever it requests.
   always_comb begin
      gnt_any  = bus.m0_req | bus.m1_req;
      gnt_port = 1'b0;
      if (!bus.m0_req && bus.m1_req) begin
         gnt_port = 1'b1;
      end
   end
`endif

   // Access sequencer with registered outputs; strobe and ready default low each cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
         m0_ready_q  <= 1'b0;
         m1_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         owner_q     <= 1'b0;
      end else begin
         mem_en_q   <= 1'b0;
         m0_ready_q <= 1'b0;
         m1_ready_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (gnt_any) begin
                  // Grant is committed here; later req changes do not abort it.
                  state_q     <= StAccess;
                  owner_q     <= gnt_port;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= gnt_port ? bus.m1_we : bus.m0_we;
                  mem_addr_q  <= gnt_port ? bus.m1_addr : bus.m0_addr;
                  mem_wdata_q <= gnt_port ? bus.m1_wdata : bus.m0_wdata;
                  cnt_q       <= LatCnt;
                  busy_q      <= 1'b1;
               end
            end
            StAccess: begin
               if (cnt_q == 4'd1) begin
                  // Last wait cycle: read data is valid, capture into the owner only.
                  if (!mem_we_q) begin
                     if (owner_q) begin
                        m1_rdata_q <= bus.mem_rdata;
                     end else begin
                        m0_rdata_q <= bus.mem_rdata;
                     end
                  end
                  m0_ready_q <= ~owner_q;
                  m1_ready_q <= owner_q;
                  state_q    <= StResp;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StResp: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.m0_rdata  = m0_rdata_q;
   assign bus.m1_rdata  = m1_rdata_q;
   assign bus.m0_ready  = m0_ready_q;
   assign bus.m1_ready  = m1_ready_q;
   assign bus.busy      = busy_q;
   assign bus.owner     = owner_q;

   // Only one requester can be completing at a time.
   a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
      !(m0_ready_q && m1_ready_q));

   // The memory strobe never lasts more than one cycle.
   a_strobe_single: assert property (@(posedge clk) disable iff (rst)
      mem_en_q |=> !mem_en_q);

   // Ready is only ever presented in the response state.
   a_ready_in_resp: assert property (@(posedge clk) disable iff (rst)
      (m0_ready_q || m1_ready_q) |-> (state_q == StResp));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter. Stimulus pushes expected strobes and
// completions into queues; a negedge monitor pops and compares as the DUT presents them.
module tb_mem_arbiter;

   localparam int unsigned AW  = 10;
   localparam int unsigned DW  = 32;
   localparam int unsigned LAT = 3;

   typedef struct {
      int          cyc;
      bit          port;
      logic [31:0] rdata;
   } rdy_t;

   typedef struct {
      int          cyc;
      bit          we;
      logic [9:0]  addr;
      logic [31:0] data;
   } strobe_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .MEM_LAT(LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Initial memory image: a fixed word at 0x004, a hash elsewhere.
   function automatic logic [31:0] init_val(input logic [9:0] a);
      if (a == 10'h004) return 32'h1234ABCD;
      return ({22'h0, a} * 32'h9E3779B1) ^ 32'hA5C30F1E;
   endfunction

   // Memory environment: combinational read of the held address, write on strobe.
   logic [31:0] env_mem [1024];
   bit          env_wr  [1024];
   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) begin
         env_mem[bus.mem_addr] <= bus.mem_wdata;
         env_wr[bus.mem_addr]  <= 1'b1;
      end
   end
   assign bus.mem_rdata = env_wr[bus.mem_addr] ? env_mem[bus.mem_addr] : init_val(bus.mem_addr);

   // Reference model state.
   logic [31:0] ref_mem [int];
   logic [31:0] shadow [2];
   bit          rr_ptr = 1'b1;
   int          model_free = 0;
   rdy_t        rdy_q[$];
   strobe_t     mem_q[$];
   bit          hold0 = 1'b0;
   bit          hold1 = 1'b0;

   function automatic logic [31:0] ref_rd(input logic [9:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return init_val(a);
   endfunction

   function automatic bit tie_winner();
`ifdef ARB_RR_EN
      return ~rr_ptr;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Access granted in IDLE cycle g: strobe in g+1, ready in g+LAT+1, next grant g+LAT+2.
   task automatic model_grant(input bit p, input bit we, input logic [9:0] a,
                              input logic [31:0] d, input int g, input bit want_rdy);
      strobe_t s;
      rdy_t    r;
      s.cyc  = g + 1;
      s.we   = we;
      s.addr = a;
      s.data = d;
      mem_q.push_back(s);
      rr_ptr = p;
      if (want_rdy) begin
         if (we) begin
            ref_mem[int'(a)] = d;
            r.rdata = shadow[p];
         end else begin
            r.rdata   = ref_rd(a);
            shadow[p] = r.rdata;
         end
         r.cyc  = g + int'(LAT) + 1;
         r.port = p;
         rdy_q.push_back(r);
         model_free = g + int'(LAT) + 2;
      end
   endtask

   // Monitor: compare strobes and completions against the queues.
   bit          rst_seen = 1'b1;
   bit          held_valid = 1'b0;
   logic [9:0]  cur_addr;
   logic [31:0] cur_wd;
   bit          cur_we;
   rdy_t        mon_r;
   strobe_t     mon_s;

   always @(posedge clk) rst_seen <= rst;

   always @(negedge clk) begin
      if (rst_seen) held_valid = 1'b0;
      if (bus.m0_ready === 1'b1 || bus.m1_ready === 1'b1) begin
         chk("ready_onehot", 32'(bus.m0_ready & bus.m1_ready), 32'd0);
         if (rdy_q.size() == 0) begin
            chk("ready_unexpected", {30'd0, bus.m1_ready, bus.m0_ready}, 32'd0);
         end else begin
            mon_r = rdy_q.pop_front();
            chk("ready_cycle", 32'(cyc), 32'(mon_r.cyc));
            chk("ready_port", 32'(bus.m1_ready), 32'(mon_r.port));
            chk("owner", 32'(bus.owner), 32'(mon_r.port));
            chk("rdata", mon_r.port ? bus.m1_rdata : bus.m0_rdata, mon_r.rdata);
         end
      end else if (rdy_q.size() != 0 && rdy_q[0].cyc < cyc) begin
         chk("ready_missing", 32'(cyc), 32'(rdy_q[0].cyc));
         mon_r = rdy_q.pop_front();
      end
      if (bus.mem_en === 1'b1) begin
         if (mem_q.size() == 0) begin
            chk("strobe_unexpected", 32'(bus.mem_en), 32'd0);
         end else begin
            mon_s = mem_q.pop_front();
            chk("strobe_cycle", 32'(cyc), 32'(mon_s.cyc));
            chk("strobe_we", 32'(bus.mem_we), 32'(mon_s.we));
            chk("strobe_addr", 32'(bus.mem_addr), 32'(mon_s.addr));
            chk("strobe_wdata", bus.mem_wdata, mon_s.data);
            cur_addr   = mon_s.addr;
            cur_wd     = mon_s.data;
            cur_we     = mon_s.we;
            held_valid = 1'b1;
         end
      end else if (mem_q.size() != 0 && mem_q[0].cyc < cyc) begin
         chk("strobe_missing", 32'(cyc), 32'(mem_q[0].cyc));
         mon_s = mem_q.pop_front();
      end
      if (held_valid && !rst_seen) begin
         chk("mem_addr_held", 32'(bus.mem_addr), 32'(cur_addr));
         chk("mem_wdata_held", bus.mem_wdata, cur_wd);
         chk("mem_we_held", 32'(bus.mem_we), 32'(cur_we));
      end
   end

   // Stimulus helpers; a requester drops req when it sees its ready unless holding.
   task automatic step();
      @(negedge clk);
      if (bus.m0_ready === 1'b1 && !hold0) bus.m0_req = 1'b0;
      if (bus.m1_ready === 1'b1 && !hold1) bus.m1_req = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && cyc < model_free; i++) step();
   endtask

   task automatic drive(input bit p, input bit we, input logic [9:0] a, input logic [31:0] d);
      if (p) begin
         bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
      end else begin
         bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
      end
   endtask

   task automatic issue(input bit p, input bit we, input logic [9:0] a, input logic [31:0] d);
      drive(p, we, a, d);
      if (p) bus.m1_req = 1'b1;
      else   bus.m0_req = 1'b1;
      model_grant(p, we, a, d, cyc, 1'b1);
   endtask

   task automatic issue_pair(input bit we0, input logic [9:0] a0, input logic [31:0] d0,
                             input bit we1, input logic [9:0] a1, input logic [31:0] d1);
      int c;
      bit w;
      c = cyc;
      drive(1'b0, we0, a0, d0);
      drive(1'b1, we1, a1, d1);
      bus.m0_req = 1'b1;
      bus.m1_req = 1'b1;
      w = tie_winner();
      if (!w) begin
         model_grant(1'b0, we0, a0, d0, c, 1'b1);
         model_grant(1'b1, we1, a1, d1, c + int'(LAT) + 2, 1'b1);
      end else begin
         model_grant(1'b1, we1, a1, d1, c, 1'b1);
         model_grant(1'b0, we0, a0, d0, c + int'(LAT) + 2, 1'b1);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
      chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
      chk({tag, "_ready"}, {30'd0, bus.m1_ready, bus.m0_ready}, 32'd0);
      chk({tag, "_owner"}, 32'(bus.owner), 32'd0);
      chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
      chk({tag, "_m0_rdata"}, bus.m0_rdata, 32'd0);
      chk({tag, "_m1_rdata"}, bus.m1_rdata, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int n;
      int lows;
      bit seen;
      bit w;
      int pat;
      bit we0, we1;
      logic [9:0] a0, a1;
      logic [31:0] d0, d1;

      bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
      bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
      shadow[0] = '0;
      shadow[1] = '0;

      // Reset
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset("init");
      model_free = cyc;

      // Single read from port 0
      issue(1'b0, 1'b0, 10'h004, 32'h0);
      wait_idle();
      chk("read_0x004", bus.m0_rdata, 32'h1234ABCD);

      // Single write from port 1 at the top address
      issue(1'b1, 1'b1, 10'h3FF, 32'hDEADBEEF);
      wait_idle();
      chk("write_landed", env_mem[10'h3FF], 32'hDEADBEEF);
      chk("m1_rdata_after_write", bus.m1_rdata, shadow[1]);

      // Read back through port 0
      issue(1'b0, 1'b0, 10'h3FF, 32'h0);
      wait_idle();

      // Port 1 drops req in the first access cycle; completion still happens
      issue(1'b1, 1'b0, 10'h004, 32'h0);
      step();
      bus.m1_req = 1'b0;
      wait_idle();
      chk("m1_rdata_after_drop", bus.m1_rdata, 32'h1234ABCD);

      // Back-to-back: port 0 holds req across three reads
      c = cyc;
      hold0 = 1'b1;
      drive(1'b0, 1'b0, 10'h010, 32'h0);
      bus.m0_req = 1'b1;
      model_grant(1'b0, 1'b0, 10'h010, 32'h0, c, 1'b1);
      model_grant(1'b0, 1'b0, 10'h011, 32'h0, c + int'(LAT) + 2, 1'b1);
      model_grant(1'b0, 1'b0, 10'h012, 32'h0, c + 2 * (int'(LAT) + 2), 1'b1);
      n = 0; lows = 0; seen = 1'b0;
      for (int t = 0; t < 60 && n < 3; t++) begin
         step();
         if (seen && bus.busy !== 1'b1) lows++;
         if (bus.m0_ready === 1'b1) begin
            n++;
            seen = 1'b1;
            if (n == 1) bus.m0_addr = 10'h011;
            else if (n == 2) bus.m0_addr = 10'h012;
            else begin
               bus.m0_req = 1'b0;
               hold0 = 1'b0;
            end
         end
      end
      chk("b2b_readies", 32'(n), 32'd3);
      chk("b2b_busy_low", 32'(lows), 32'd2);
      bus.m0_req = 1'b0;
      hold0 = 1'b0;
      wait_idle();

      // Contention: both ports hold req through four arbitrations
      c = cyc;
      hold0 = 1'b1;
      hold1 = 1'b1;
      drive(1'b0, 1'b0, 10'h020, 32'h0);
      drive(1'b1, 1'b0, 10'h030, 32'h0);
      bus.m0_req = 1'b1;
      bus.m1_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         w = tie_winner();
         model_grant(w, 1'b0, w ? 10'h030 : 10'h020, 32'h0, c + k * (int'(LAT) + 2), 1'b1);
      end
      n = 0;
      for (int t = 0; t < 80 && n < 4; t++) begin
         step();
         if (bus.m0_ready === 1'b1 || bus.m1_ready === 1'b1) n++;
      end
      chk("contention_grants", 32'(n), 32'd4);
      bus.m0_req = 1'b0;
      bus.m1_req = 1'b0;
      hold0 = 1'b0;
      hold1 = 1'b0;
      wait_idle();

      // Reset during the first access cycle of a port 0 read
      c = cyc;
      drive(1'b0, 1'b0, 10'h055, 32'h0);
      bus.m0_req = 1'b1;
      model_grant(1'b0, 1'b0, 10'h055, 32'h0, c, 1'b0);
      step();
      rst = 1'b1;
      bus.m0_req = 1'b0;
      step();
      check_reset("mid_reset");
      rst = 1'b0;
      shadow[0] = '0;
      shadow[1] = '0;
      rr_ptr = 1'b1;
      model_free = cyc;

      // Tie straight after reset exercises the reset pointer value
      issue_pair(1'b0, 10'h004, 32'h0, 1'b0, 10'h3FF, 32'h0);
      wait_idle();

      // Random traffic
      for (int it = 0; it < 40; it++) begin
         wait_idle();
         repeat ($urandom_range(0, 2)) step();
         pat = int'($urandom_range(0, 2));
         we0 = 1'($urandom_range(0, 1));
         we1 = 1'($urandom_range(0, 1));
         a0  = 10'($urandom_range(0, 15));
         a1  = 10'($urandom_range(0, 15));
         d0  = $urandom;
         d1  = $urandom;
         if (pat == 2) begin
            issue_pair(we0, a0, d0, we1, a1, d1);
         end else begin
            issue(pat == 1, we0, a0, d0);
            if ($urandom_range(0, 3) == 0) begin
               step();
               if (pat == 1) bus.m1_req = 1'b0;
               else          bus.m0_req = 1'b0;
            end
         end
      end
      wait_idle();
      repeat (3) step();
      chk("ready_queue_drained", 32'(rdy_q.size()), 32'd0);
      chk("strobe_queue_drained", 32'(mem_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
